memory_turn_ctrl: RTL and testbench

Turn sequencer for the two-player memory game. It drives the command inputs of `game_datapath`: first and second selection (manual or automatic on timeout), match acknowledge, mismatch pause and end of turn. It enforces the per-turn time limit on the 1 Hz tick and parks in a terminal state when the datapath reports game over. It sits between the board-level button/tick logic and `game_datapath` in the Lab 3 top level.

---
 rtl/memory_turn_ctrl_pkg.sv | 14 +
 rtl/memory_turn_ctrl_turn_timer.sv | 30 +++
 rtl/memory_turn_ctrl.sv | 141 ++++++++++++++
 tb/tb_memory_turn_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/memory_turn_ctrl_pkg.sv
// Shared Lab 3 definitions: turn sequencer state encoding and default turn length.
package lab3_params;

   typedef enum logic [2:0] {
      TS_WAIT1 = 3'd0,
      TS_WAIT2 = 3'd1,
      TS_POST  = 3'd2,
      TS_PAUSE = 3'd3,
      TS_OVER  = 3'd4
   } turn_state_e;

   localparam int TURN_SECONDS_DEF = 15;

endpackage

// File: rtl/memory_turn_ctrl_turn_timer.sv
// Per-pick countdown timer: loadable 5-bit down-counter that saturates at zero.
module turn_timer #(
   parameter logic [4:0] RELOAD = 5'd15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic       freeze_i,
   input  logic       tick_i,
   output logic [4:0] count_o,
   output logic       zero_o
);

   logic [4:0] r_count;

   // Reload has priority over a coincident tick; counting stops at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= RELOAD;
      end else if (load_i) begin
         r_count <= RELOAD;
      end else if (tick_i && !freeze_i && (r_count != 5'd0)) begin
         r_count <= r_count - 5'd1;
      end
   end

   assign count_o = r_count;
   assign zero_o  = (r_count == 5'd0);

endmodule

// File: rtl/memory_turn_ctrl.sv
// Turn sequencer for the two-player memory game: issues datapath commands for
// manual/automatic selections, match handling, mismatch pause and end of turn.
//
// Command outputs are single-cycle pulses decoded combinationally from the
// current state and inputs; there is no ready/back-pressure. Every command
// coincides with a state change, so no command is high on two adjacent cycles.
module memory_turn_ctrl
   import lab3_params::*;
#(
   parameter int TURN_SECONDS = TURN_SECONDS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_sel_i,
   input  logic       tick_1hz_i,
   input  logic       hl_card_down_i,
   input  logic       cards_match_i,
   input  logic       pause_done_i,
   input  logic       auto_pick1_valid_i,
   input  logic       auto_pick2_valid_i,
   input  logic       game_over_i,
   output logic       select_first_card_o,
   output logic       select_second_card_o,
   output logic       auto_select_first_o,
   output logic       auto_select_second_o,
   output logic       match_found_o,
   output logic       extra_turn_o,
   output logic       start_pause_o,
   output logic       end_turn_o,
   output logic [4:0] turn_secs_o,
   output logic [2:0] state_o,
   output logic       timeout_o
);

   localparam logic [4:0] RELOAD = 5'(TURN_SECONDS);

   turn_state_e r_state;
   turn_state_e w_next;
   logic        w_load;
   logic        w_freeze;
   logic        w_sel;
   logic        w_zero;
   logic        w_waiting;
   logic [4:0]  w_count;

   assign w_sel     = btn_sel_i && hl_card_down_i;
   assign w_waiting = (r_state == TS_WAIT1) || (r_state == TS_WAIT2);
   assign w_freeze  = !w_waiting;

   turn_timer #(
      .RELOAD (RELOAD)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (w_load),
      .freeze_i (w_freeze),
      .tick_i   (tick_1hz_i),
      .count_o  (w_count),
      .zero_o   (w_zero)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= TS_WAIT1;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state, timer reload and command decode.
   always_comb begin
      w_next               = r_state;
      w_load               = 1'b0;
      select_first_card_o  = 1'b0;
      select_second_card_o = 1'b0;
      auto_select_first_o  = 1'b0;
      auto_select_second_o = 1'b0;
      match_found_o        = 1'b0;
      extra_turn_o         = 1'b0;
      start_pause_o        = 1'b0;
      end_turn_o           = 1'b0;
      unique case (r_state)
         TS_WAIT1: begin
            if (game_over_i) begin
               w_next = TS_OVER;
            end else if (w_sel) begin
               select_first_card_o = 1'b1;
               w_next              = TS_WAIT2;
               w_load              = 1'b1;
            end else if (w_zero && auto_pick1_valid_i) begin
               auto_select_first_o = 1'b1;
               w_next              = TS_WAIT2;
               w_load              = 1'b1;
            end
         end
         TS_WAIT2: begin
            if (w_sel || (w_zero && auto_pick2_valid_i)) begin
               select_second_card_o = w_sel;
               auto_select_second_o = !w_sel;
               if (cards_match_i) begin
                  match_found_o = 1'b1;
                  extra_turn_o  = 1'b1;
                  w_next        = TS_POST;
               end else begin
                  start_pause_o = 1'b1;
                  w_next        = TS_PAUSE;
               end
            end
         end
         TS_POST: begin
            // One idle cycle so the datapath score/game-over flag settles.
            if (game_over_i) begin
               w_next = TS_OVER;
            end else begin
               w_next = TS_WAIT1;
               w_load = 1'b1;
            end
         end
         TS_PAUSE: begin
            if (pause_done_i) begin
               end_turn_o = 1'b1;
               w_next     = TS_WAIT1;
               w_load     = 1'b1;
            end
         end
         TS_OVER: begin
            w_next = TS_OVER;
         end
         default: begin
            w_next = TS_WAIT1;
            w_load = 1'b1;
         end
      endcase
   end

   assign turn_secs_o = w_count;
   assign state_o     = r_state;
   assign timeout_o   = w_zero && w_waiting;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Directed bench for memory_turn_ctrl with an expected-value queue.
module tb_memory_turn_ctrl;

   localparam logic [7:0] C_SF = 8'h80;
   localparam logic [7:0] C_SS = 8'h40;
   localparam logic [7:0] C_AF = 8'h20;
   localparam logic [7:0] C_AS = 8'h10;
   localparam logic [7:0] C_MF = 8'h08;
   localparam logic [7:0] C_ET = 8'h04;
   localparam logic [7:0] C_SP = 8'h02;
   localparam logic [7:0] C_EN = 8'h01;

   logic clk = 1'b0;
   logic rst_n;
   logic btn, tick, hl, match, pdone, ap1, ap2, go;
   logic sf, ss, af, as_o, mf, et, sp, en, to;
   logic [4:0] secs;
   logic [2:0] st;
   logic [16:0] obs;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   memory_turn_ctrl #(.TURN_SECONDS(15)) u_dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .btn_sel_i            (btn),
      .tick_1hz_i           (tick),
      .hl_card_down_i       (hl),
      .cards_match_i        (match),
      .pause_done_i         (pdone),
      .auto_pick1_valid_i   (ap1),
      .auto_pick2_valid_i   (ap2),
      .game_over_i          (go),
      .select_first_card_o  (sf),
      .select_second_card_o (ss),
      .auto_select_first_o  (af),
      .auto_select_second_o (as_o),
      .match_found_o        (mf),
      .extra_turn_o         (et),
      .start_pause_o        (sp),
      .end_turn_o           (en),
      .turn_secs_o          (secs),
      .state_o              (st),
      .timeout_o            (to)
   );

   assign obs = {sf, ss, af, as_o, mf, et, sp, en, secs, st, to};

   function automatic logic [16:0] ev(input logic [7:0] c, input logic [4:0] s,
                                      input logic [2:0] state, input logic t);
      return {c, s, state, t};
   endfunction

   // scoreboard: push the expectation for this cycle, compare at negedge,
   // then advance to just after the next posedge and drop pulse inputs.
   task automatic chk(input string tag, input logic [16:0] e);
      logic [16:0] x;
      exp_q.push_back(e);
      @(negedge clk);
      x = exp_q.pop_front();
      checks++;
      assert (obs === x) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, x);
      end
      @(posedge clk);
      #1;
      btn   = 1'b0;
      tick  = 1'b0;
      pdone = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; btn = 0; tick = 0; hl = 0; match = 0;
      pdone = 0; ap1 = 0; ap2 = 0; go = 0;
      @(posedge clk);
      #1;
      chk("reset", ev(8'h00, 5'd15, 3'd0, 1'b0));
      rst_n = 1'b1;

      // manual match
      hl = 1'b1;
      btn = 1'b1;                chk("m_sel1", ev(C_SF, 5'd15, 3'd0, 1'b0));
      btn = 1'b1; match = 1'b1;  chk("m_sel2", ev(C_SS | C_MF | C_ET, 5'd15, 3'd1, 1'b0));
      match = 1'b0;              chk("m_post", ev(8'h00, 5'd15, 3'd2, 1'b0));
      chk("m_wait1", ev(8'h00, 5'd15, 3'd0, 1'b0));
      tick = 1'b1;               chk("tick1", ev(8'h00, 5'd15, 3'd0, 1'b0));
      chk("dec1", ev(8'h00, 5'd14, 3'd0, 1'b0));

      // manual mismatch, pause holds the timer
      btn = 1'b1;                chk("mm_sel1", ev(C_SF, 5'd14, 3'd0, 1'b0));
      btn = 1'b1;                chk("mm_sel2", ev(C_SS | C_SP, 5'd15, 3'd1, 1'b0));
      for (int i = 0; i < 20; i++) begin
         tick = 1'b1;            chk("pause_tick", ev(8'h00, 5'd15, 3'd3, 1'b0));
      end
      pdone = 1'b1;              chk("pause_done", ev(C_EN, 5'd15, 3'd3, 1'b0));
      chk("mm_wait1", ev(8'h00, 5'd15, 3'd0, 1'b0));

      // button on a face-up card is ignored, timer keeps counting
      hl = 1'b0; btn = 1'b1; tick = 1'b1;
      chk("ign_sel", ev(8'h00, 5'd15, 3'd0, 1'b0));
      hl = 1'b1;
      chk("ign_dec", ev(8'h00, 5'd14, 3'd0, 1'b0));

      // count down in WAIT1, hold at 0 without a valid auto pick
      for (int i = 0; i < 14; i++) begin
         tick = 1'b1;            chk("w1_count", ev(8'h00, 5'(14 - i), 3'd0, 1'b0));
      end
      chk("w1_hold", ev(8'h00, 5'd0, 3'd0, 1'b1));
      tick = 1'b1;               chk("w1_sat", ev(8'h00, 5'd0, 3'd0, 1'b1));
      ap1 = 1'b1;                chk("auto1", ev(C_AF, 5'd0, 3'd0, 1'b1));
      ap1 = 1'b0;                chk("auto1_next", ev(8'h00, 5'd15, 3'd1, 1'b0));

      // WAIT2 timeout collides with select: select wins
      for (int i = 0; i < 15; i++) begin
         tick = 1'b1;            chk("w2_count", ev(8'h00, 5'(15 - i), 3'd1, 1'b0));
      end
      ap2 = 1'b1; btn = 1'b1;    chk("col_sel", ev(C_SS | C_SP, 5'd0, 3'd1, 1'b1));
      ap2 = 1'b0;                chk("col_pause", ev(8'h00, 5'd0, 3'd3, 1'b0));
      pdone = 1'b1;              chk("col_end", ev(C_EN, 5'd0, 3'd3, 1'b0));

      // reload coinciding with a tick: reload wins
      btn = 1'b1; tick = 1'b1;   chk("rl_sel", ev(C_SF, 5'd15, 3'd0, 1'b0));
      chk("rl_val", ev(8'h00, 5'd15, 3'd1, 1'b0));

      // automatic second pick with match, then game over
      for (int i = 0; i < 14; i++) begin
         tick = 1'b1;            chk("w2b_count", ev(8'h00, 5'(15 - i), 3'd1, 1'b0));
      end
      tick = 1'b1;               chk("w2b_last", ev(8'h00, 5'd1, 3'd1, 1'b0));
      chk("w2_hold", ev(8'h00, 5'd0, 3'd1, 1'b1));
      ap2 = 1'b1; match = 1'b1;  chk("auto2", ev(C_AS | C_MF | C_ET, 5'd0, 3'd1, 1'b1));
      ap2 = 1'b0; match = 1'b0; go = 1'b1;
      chk("go_post", ev(8'h00, 5'd0, 3'd2, 1'b0));
      btn = 1'b1; tick = 1'b1;   chk("over1", ev(8'h00, 5'd0, 3'd4, 1'b0));
      go = 1'b0; btn = 1'b1; ap1 = 1'b1;
      chk("over2", ev(8'h00, 5'd0, 3'd4, 1'b0));
      ap1 = 1'b0;

      // reset out of OVER
      rst_n = 1'b0;              chk("rst_over", ev(8'h00, 5'd0, 3'd4, 1'b0));
      rst_n = 1'b1;              chk("rst_over_after", ev(8'h00, 5'd15, 3'd0, 1'b0));

      // reset mid-pause
      btn = 1'b1;                chk("rp_sel1", ev(C_SF, 5'd15, 3'd0, 1'b0));
      tick = 1'b1;               chk("rp_t1", ev(8'h00, 5'd15, 3'd1, 1'b0));
      tick = 1'b1;               chk("rp_t2", ev(8'h00, 5'd14, 3'd1, 1'b0));
      btn = 1'b1;                chk("rp_sel2", ev(C_SS | C_SP, 5'd13, 3'd1, 1'b0));
      rst_n = 1'b0;              chk("rp_pause", ev(8'h00, 5'd13, 3'd3, 1'b0));
      rst_n = 1'b1;              chk("rp_after", ev(8'h00, 5'd15, 3'd0, 1'b0));

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
